// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the dynamic branch predictor.
//   cnt2State : encodings of a 2-bit saturating counter (strongly/weakly
//               not-taken, weakly/strongly taken).
//   BP_*      : values of the branch_predictor MODE parameter.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt2State;

  localparam int BP_BIMODAL = 0;
  localparam int BP_GSHARE  = 1;

endpackage

// File: rtl/branch_predictor_sat.sv
// sat_counter_next: next value of a CNT_W-bit saturating up/down counter.
//   cur   in  CNT_W : present counter value
//   taken in  1     : 1 = step up (saturate at all-ones), 0 = step down (saturate at 0)
//   next  out CNT_W : value after one training step
module sat_counter_next
  import branch_predictor_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cur,
  input  logic             taken,
  output logic [CNT_W-1:0] next
);

  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != {CNT_W{1'b1}}) next = cur + 1'b1;
    end else begin
      if (cur != '0) next = cur - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: table of saturating counters that predicts conditional
// branches in decode and is trained from the memory stage, in bimodal
// (PC-indexed) or gshare (PC XOR global history) mode, with resolved-branch
// and mispredict statistics.
//   clk            in  1       : rising-edge clock
//   rst            in  1       : asynchronous reset, active low
//   lookup_en      in  1       : decode holds a conditional branch
//   lookup_pc      in  32      : PC of the decode instruction
//   pred_take      out 1       : prediction (combinational, 0 when lookup_en=0)
//   pred_idx       out INDEX_W : table index used by this lookup
//   upd_en         in  1       : a branch resolves this cycle
//   upd_idx        in  INDEX_W : pred_idx carried with the resolving branch
//   upd_taken      in  1       : actual outcome
//   upd_mispredict in  1       : the prediction was wrong
//   stats_clr      in  1       : synchronous clear of br_cnt / miss_cnt
//   br_cnt         out 32      : resolved branches (saturating)
//   miss_cnt       out 32      : mispredicts (saturating)
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_W   = 6,
  parameter int CNT_W     = 2,
  parameter int MODE      = BP_GSHARE,
  parameter int GHR_W     = 6,
  parameter int RESET_CNT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lookup_en,
  input  logic [31:0]        lookup_pc,
  output logic               pred_take,
  output logic [INDEX_W-1:0] pred_idx,
  input  logic               upd_en,
  input  logic [INDEX_W-1:0] upd_idx,
  input  logic               upd_taken,
  input  logic               upd_mispredict,
  input  logic               stats_clr,
  output logic [31:0]        br_cnt,
  output logic [31:0]        miss_cnt
);

  localparam int               ENTRIES   = 1 << INDEX_W;
  localparam logic [CNT_W-1:0] RESET_VAL = CNT_W'(RESET_CNT);

  logic [CNT_W-1:0]   cntTable [ENTRIES];
  logic [GHR_W-1:0]   ghr;
  logic [GHR_W-1:0]   ghrNext;
  logic [INDEX_W-1:0] pcIdx;
  logic [INDEX_W-1:0] ghrExt;
  logic [INDEX_W-1:0] lookupIdx;
  logic [CNT_W-1:0]   updCur;
  logic [CNT_W-1:0]   updNext;
  logic [31:0]        brCnt;
  logic [31:0]        missCnt;
  logic               unusedBits;

  function automatic logic [31:0] satInc(input logic [31:0] value, input logic inc);
    if (inc && (value != 32'hFFFF_FFFF)) return value + 32'd1;
    return value;
  endfunction

  // Word-aligned PC bits select the entry; byte offset and high bits are unused.
  assign pcIdx      = lookup_pc[INDEX_W+1:2];
  assign unusedBits = ^{lookup_pc[31:INDEX_W+2], lookup_pc[1:0], ghrExt};

  // History is aligned to the index LSBs; upper index bits come from the PC only.
  always_comb begin
    ghrExt              = '0;
    ghrExt[GHR_W-1:0]   = ghr;
  end

  generate
    if (MODE == BP_GSHARE) begin : gIdxGshare
      assign lookupIdx = pcIdx ^ ghrExt;
    end else begin : gIdxBimodal
      assign lookupIdx = pcIdx;
    end

    if (GHR_W == 1) begin : gGhrOne
      assign ghrNext = upd_taken;
    end else begin : gGhrShift
      assign ghrNext = {ghr[GHR_W-2:0], upd_taken};
    end
  endgenerate

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign pred_idx  = lookupIdx;
  assign pred_take = lookup_en & cntTable[lookupIdx][CNT_W-1];

  assign updCur = cntTable[upd_idx];

  sat_counter_next #(
    .CNT_W (CNT_W)
  ) uSatNext (
    .cur   (updCur),
    .taken (upd_taken),
    .next  (updNext)
  );

  // Table and history train only on resolved branches (non-speculative).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) cntTable[i] <= RESET_VAL;
      ghr <= '0;
    end else if (upd_en) begin
      cntTable[upd_idx] <= updNext;
      ghr               <= ghrNext;
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brCnt   <= '0;
      missCnt <= '0;
    end else if (stats_clr) begin
      brCnt   <= '0;
      missCnt <= '0;
    end else begin
      brCnt   <= satInc(brCnt, upd_en);
      missCnt <= satInc(missCnt, upd_en & upd_mispredict);
    end
  end

  assign br_cnt   = brCnt;
  assign miss_cnt = missCnt;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam logic [31:0] PC4 = 32'hBFC0_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookupEn;
  logic [31:0] lookupPc;
  logic        updEn;
  logic [5:0]  updIdx;
  logic        updTaken;
  logic        updMispredict;
  logic        statsClr;

  logic        predBi, predGs;
  logic [5:0]  idxBi, idxGs;
  logic [31:0] brBi, brGs, missBi, missGs;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_W(6), .CNT_W(2), .MODE(0), .GHR_W(6), .RESET_CNT(1)) dutBi (
    .clk(clk), .rst(rst), .lookup_en(lookupEn), .lookup_pc(lookupPc),
    .pred_take(predBi), .pred_idx(idxBi), .upd_en(updEn), .upd_idx(updIdx),
    .upd_taken(updTaken), .upd_mispredict(updMispredict), .stats_clr(statsClr),
    .br_cnt(brBi), .miss_cnt(missBi));

  branch_predictor #(.INDEX_W(6), .CNT_W(2), .MODE(1), .GHR_W(6), .RESET_CNT(1)) dutGs (
    .clk(clk), .rst(rst), .lookup_en(lookupEn), .lookup_pc(lookupPc),
    .pred_take(predGs), .pred_idx(idxGs), .upd_en(updEn), .upd_idx(updIdx),
    .upd_taken(updTaken), .upd_mispredict(updMispredict), .stats_clr(statsClr),
    .br_cnt(brGs), .miss_cnt(missGs));

  // Reference model: plain integer counters, history and statistics.
  int     tblBi [64];
  int     tblGs [64];
  int     mGhr;
  longint mBr, mMiss;
  int     nChecks = 0;
  int     nFails  = 0;
  logic   lastPredBi, lastPredGs;
  logic [5:0] lastIdxGs;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mIdx(input logic [31:0] pc, input bit gshare);
    int p;
    p = int'((pc >> 2) % 64);
    return gshare ? (p ^ (mGhr % 64)) : p;
  endfunction

  function automatic int train(input int c, input bit taken);
    if (taken) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 64; i++) begin
      tblBi[i] = 1;
      tblGs[i] = 1;
    end
    mGhr  = 0;
    mBr   = 0;
    mMiss = 0;
  endfunction

  // One cycle: apply inputs after a falling edge, check the combinational
  // lookup against pre-update state, advance the model at the rising edge,
  // then check the statistics at the next falling edge.
  task automatic doCycle(input bit le, input logic [31:0] pc, input bit ue, input int ui,
                         input bit ut, input bit um, input bit sc);
    int eB, eG;
    lookupEn = le; lookupPc = pc; updEn = ue; updIdx = 6'(ui);
    updTaken = ut; updMispredict = um; statsClr = sc;
    #1;
    eB = mIdx(pc, 0);
    eG = mIdx(pc, 1);
    checkVal("idxBi", 64'(idxBi), 64'(eB));
    checkVal("idxGs", 64'(idxGs), 64'(eG));
    checkVal("predBi", 64'(predBi), 64'(le && (tblBi[eB] >= 2)));
    checkVal("predGs", 64'(predGs), 64'(le && (tblGs[eG] >= 2)));
    lastPredBi = predBi;
    lastPredGs = predGs;
    lastIdxGs  = idxGs;
    @(posedge clk);
    if (ue) begin
      tblBi[ui] = train(tblBi[ui], ut);
      tblGs[ui] = train(tblGs[ui], ut);
      mGhr = ((mGhr << 1) | int'(ut)) % 64;
    end
    if (sc) begin
      mBr = 0;
      mMiss = 0;
    end else if (ue) begin
      if (mBr < 64'hFFFF_FFFF) mBr++;
      if (um && mMiss < 64'hFFFF_FFFF) mMiss++;
    end
    @(negedge clk);
    checkVal("brBi", 64'(brBi), mBr);
    checkVal("missBi", 64'(missBi), mMiss);
    checkVal("brGs", 64'(brGs), mBr);
    checkVal("missGs", 64'(missGs), mMiss);
  endtask

  initial begin
    logic [31:0] pc;
    bit          le, ue, ut, um, sc;
    int          ui;

    rst = 1'b0;
    lookupEn = 1'b1; lookupPc = PC4; updEn = 1'b0; updIdx = '0;
    updTaken = 1'b0; updMispredict = 1'b0; statsClr = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkVal("rst_predBi", 64'(predBi), 64'd0);
    checkVal("rst_idxBi", 64'(idxBi), 64'd4);
    checkVal("rst_idxGs", 64'(idxGs), 64'd4);
    checkVal("rst_br", 64'(brBi), 64'd0);
    checkVal("rst_miss", 64'(missGs), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Every entry starts weakly not-taken.
    for (int i = 0; i < 64; i++) doCycle(1, 32'(i) << 2, 0, 0, 0, 0, 0);

    // Bimodal training of idx 4.
    doCycle(0, 0, 1, 4, 1, 0, 0);
    doCycle(0, 0, 1, 4, 1, 0, 0);
    doCycle(1, PC4, 0, 0, 0, 0, 0);
    checkVal("bi_two_taken", 64'(lastPredBi), 64'd1);
    for (int i = 0; i < 3; i++) doCycle(0, 0, 1, 4, 1, 0, 0);
    doCycle(0, 0, 1, 4, 0, 0, 0);
    doCycle(1, PC4, 0, 0, 0, 0, 0);
    checkVal("bi_sat_then_nt", 64'(lastPredBi), 64'd1);
    doCycle(0, 0, 1, 4, 0, 0, 0);
    doCycle(1, PC4, 0, 0, 0, 0, 0);
    checkVal("bi_back_to_wnt", 64'(lastPredBi), 64'd0);

    // Same-cycle lookup and update of the same entry (counter 1).
    doCycle(1, PC4, 1, 4, 1, 0, 0);
    checkVal("hazard_same", 64'(lastPredBi), 64'd0);
    doCycle(1, PC4, 0, 0, 0, 0, 0);
    checkVal("hazard_next", 64'(lastPredBi), 64'd1);

    // Gshare history: flush, then T, T, NT.
    for (int i = 0; i < 3; i++) doCycle(0, 0, 1, 10, 0, 0, 0);
    doCycle(0, 0, 1, 10, 1, 0, 0);
    doCycle(0, 0, 1, 10, 1, 0, 0);
    doCycle(0, 0, 1, 10, 0, 0, 0);
    doCycle(1, 32'h0000_0040, 0, 0, 0, 0, 0);
    checkVal("gshare_idx22", 64'(lastIdxGs), 64'd22);

    // Statistics.
    doCycle(0, 0, 0, 0, 0, 0, 1);
    doCycle(0, 0, 1, 3, 1, 1, 0);
    doCycle(0, 0, 1, 3, 1, 0, 0);
    doCycle(0, 0, 0, 3, 1, 1, 0);
    doCycle(0, 0, 1, 3, 0, 1, 0);
    doCycle(0, 0, 1, 3, 0, 0, 0);
    doCycle(0, 0, 1, 3, 1, 0, 0);
    checkVal("stats_br5", 64'(brBi), 64'd5);
    checkVal("stats_miss2", 64'(missBi), 64'd2);
    doCycle(0, 0, 1, 7, 1, 1, 1);
    checkVal("stats_clr_br", 64'(brGs), 64'd0);
    checkVal("stats_clr_miss", 64'(missGs), 64'd0);

    // Randomized traffic, biased toward same-index hazards.
    for (int n = 0; n < 600; n++) begin
      pc = $urandom;
      le = ($urandom_range(0, 3) != 0);
      ue = ($urandom_range(0, 2) != 0);
      ut = ($urandom_range(0, 1) == 1);
      um = ($urandom_range(0, 1) == 1);
      sc = ($urandom_range(0, 31) == 0);
      ui = ($urandom_range(0, 1) == 1) ? mIdx(pc, 0) : int'($urandom_range(0, 63));
      doCycle(le, pc, ue, ui, ut, um, sc);
    end

    // br_cnt saturation at all-ones.
    lookupEn = 1'b0; updEn = 1'b0; statsClr = 1'b0; updMispredict = 1'b0;
    force dutBi.brCnt = 32'hFFFF_FFFF;
    #1;
    release dutBi.brCnt;
    updEn = 1'b1; updIdx = 6'd9; updTaken = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkVal("br_saturate", 64'(brBi), 64'hFFFF_FFFF);
    checkVal("br_plain_inc", 64'(brGs), (mBr < 64'hFFFF_FFFF) ? mBr + 1 : mBr);

    // Asynchronous reset between edges, with an update held in flight.
    lookupEn = 1'b1; lookupPc = PC4; updEn = 1'b1; updIdx = 6'd4; updTaken = 1'b1;
    statsClr = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkVal("arst_predBi", 64'(predBi), 64'd0);
    checkVal("arst_predGs", 64'(predGs), 64'd0);
    checkVal("arst_idxGs", 64'(idxGs), 64'd4);
    checkVal("arst_brBi", 64'(brBi), 64'd0);
    checkVal("arst_missGs", 64'(missGs), 64'd0);
    @(posedge clk);
    @(negedge clk);
    updEn = 1'b0;
    rst = 1'b1;
    #1;
    checkVal("arst_discard_bi", 64'(predBi), 64'd0);
    checkVal("arst_discard_gs", 64'(predGs), 64'd0);
    checkVal("arst_br_hold", 64'(brGs), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
